// File: rtl/axis_traffic_gen_if.sv
// Control (AXI-lite) and outstream (AXI-Stream) signal bundle for axis_traffic_gen.
// Pure wiring, no latency.
// slave modport = generator side (control slave, stream source); master = host/sink side.
interface axis_traffic_gen_if #(
    parameter int DATA_BYTES = 4
);
    // AXI-lite write channels
    logic [31:0]             s_axi_control_awaddr;
    logic                    s_axi_control_awvalid;
    logic                    s_axi_control_awready;
    logic [31:0]             s_axi_control_wdata;
    logic [3:0]              s_axi_control_wstrb;
    logic                    s_axi_control_wvalid;
    logic                    s_axi_control_wready;
    logic [1:0]              s_axi_control_bresp;
    logic                    s_axi_control_bvalid;
    logic                    s_axi_control_bready;
    // AXI-lite read channels
    logic [31:0]             s_axi_control_araddr;
    logic                    s_axi_control_arvalid;
    logic                    s_axi_control_arready;
    logic [31:0]             s_axi_control_rdata;
    logic [1:0]              s_axi_control_rresp;
    logic                    s_axi_control_rvalid;
    logic                    s_axi_control_rready;
    // Generated stream
    logic [DATA_BYTES*8-1:0] outstream_tdata;
    logic                    outstream_tvalid;
    logic                    outstream_tready;
    logic                    outstream_tlast;

    modport slave (
        input  s_axi_control_awaddr, s_axi_control_awvalid,
        input  s_axi_control_wdata, s_axi_control_wstrb, s_axi_control_wvalid,
        input  s_axi_control_bready,
        input  s_axi_control_araddr, s_axi_control_arvalid, s_axi_control_rready,
        input  outstream_tready,
        output s_axi_control_awready, s_axi_control_wready,
        output s_axi_control_bresp, s_axi_control_bvalid,
        output s_axi_control_arready, s_axi_control_rdata,
        output s_axi_control_rresp, s_axi_control_rvalid,
        output outstream_tdata, outstream_tvalid, outstream_tlast
    );

    modport master (
        output s_axi_control_awaddr, s_axi_control_awvalid,
        output s_axi_control_wdata, s_axi_control_wstrb, s_axi_control_wvalid,
        output s_axi_control_bready,
        output s_axi_control_araddr, s_axi_control_arvalid, s_axi_control_rready,
        output outstream_tready,
        input  s_axi_control_awready, s_axi_control_wready,
        input  s_axi_control_bresp, s_axi_control_bvalid,
        input  s_axi_control_arready, s_axi_control_rdata,
        input  s_axi_control_rresp, s_axi_control_rvalid,
        input  outstream_tdata, outstream_tvalid, outstream_tlast
    );
endinterface

// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator: emits COUNT beats of BASE+n with GAP idle cycles between, AXI-lite controlled.
// Latency: first beat valid the cycle after the START write commits; register reads return one cycle after AR.
// Backpressure: beat held stable while tready low; AXI-lite channels stall via ready/valid, one write in flight.
module axis_traffic_gen #(
    parameter int DATA_BYTES = 4,
    parameter int GAP_WIDTH  = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    axis_traffic_gen_if.slave  bus
);

    localparam int DW = DATA_BYTES * 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] A_CTRL  = 8'h00;
    localparam logic [7:0] A_COUNT = 8'h10;
    localparam logic [7:0] A_GAP   = 8'h14;
    localparam logic [7:0] A_BASE  = 8'h18;
    localparam logic [7:0] A_SENT  = 8'h20;

    // ---------------- state ----------------
    logic [1:0]           state_q,     state_d;
    logic [31:0]          count_q,     count_d;
    logic [31:0]          gap_q,       gap_d;
    logic [31:0]          base_q,      base_d;
    logic [31:0]          sent_q,      sent_d;
    logic [31:0]          cnt_sh_q,    cnt_sh_d;
    logic [GAP_WIDTH-1:0] gap_sh_q,    gap_sh_d;
    logic [31:0]          base_sh_q,   base_sh_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q,   gap_cnt_d;
    logic                 stop_pend_q, stop_pend_d;

    // AXI-lite bookkeeping
    logic                 rdy_en_q;
    logic                 aw_lat_q;
    logic [7:0]           awaddr_q;
    logic                 w_lat_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 bvalid_q;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;

    // ---------------- AXI-lite handshakes ----------------
    logic        awready, wready, arready;
    logic        aw_hs, w_hs, ar_hs;
    logic        wr_commit;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] rd_mux;

    // Upper address bits are outside the decoded window.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.s_axi_control_awaddr[31:8], bus.s_axi_control_araddr[31:8]};

    // rdy_en_q keeps every ready low until the first cycle after reset release.
    assign awready = rdy_en_q & ~aw_lat_q & ~bvalid_q;
    assign wready  = rdy_en_q & ~w_lat_q  & ~bvalid_q;
    assign arready = rdy_en_q & ~rvalid_q;

    assign aw_hs = bus.s_axi_control_awvalid & awready;
    assign w_hs  = bus.s_axi_control_wvalid  & wready;
    assign ar_hs = bus.s_axi_control_arvalid & arready;

    // A channel arriving this cycle is used directly so the write commits in the cycle both halves are present.
    assign wr_addr   = aw_lat_q ? awaddr_q : bus.s_axi_control_awaddr[7:0];
    assign wr_data   = w_lat_q  ? wdata_q  : bus.s_axi_control_wdata;
    assign wr_strb   = w_lat_q  ? wstrb_q  : bus.s_axi_control_wstrb;
    assign wr_commit = (aw_lat_q | aw_hs) & (w_lat_q | w_hs);

    assign bus.s_axi_control_awready = awready;
    assign bus.s_axi_control_wready  = wready;
    assign bus.s_axi_control_arready = arready;
    assign bus.s_axi_control_bvalid  = bvalid_q;
    assign bus.s_axi_control_bresp   = 2'b00;
    assign bus.s_axi_control_rvalid  = rvalid_q;
    assign bus.s_axi_control_rdata   = rdata_q;
    assign bus.s_axi_control_rresp   = 2'b00;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    // CONTROL bits act only for the cycle the write commits; they are never stored.
    logic start_p, stop_p, start_eff;
    assign start_p   = wr_commit && (wr_addr == A_CTRL) && wr_data[0];
    assign stop_p    = wr_commit && (wr_addr == A_CTRL) && wr_data[1];
    assign start_eff = start_p & ~stop_p;

    // ---------------- stream outputs ----------------
    logic        in_run, is_last, beat_hs;
    logic [31:0] beat_sum;

    assign in_run   = (state_q == S_RUN);
    assign beat_sum = base_sh_q + sent_q;
    assign is_last  = (sent_q == (cnt_sh_q - 32'd1));
    assign beat_hs  = in_run & bus.outstream_tready;

    assign bus.outstream_tvalid = in_run;
    assign bus.outstream_tdata  = in_run ? DW'(beat_sum) : '0;
    assign bus.outstream_tlast  = in_run & is_last;

    // Register read decode; unmapped offsets read as zero.
    always_comb begin
        rd_mux = 32'd0;
        case (bus.s_axi_control_araddr[7:0])
            A_CTRL:  rd_mux = {30'd0, state_q == S_DONE, (state_q == S_RUN) || (state_q == S_GAP)};
            A_COUNT: rd_mux = count_q;
            A_GAP:   rd_mux = gap_q;
            A_BASE:  rd_mux = base_q;
            A_SENT:  rd_mux = sent_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // Register writes and run-control FSM next state.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gap_d       = gap_q;
        base_d      = base_q;
        sent_d      = sent_q;
        cnt_sh_d    = cnt_sh_q;
        gap_sh_d    = gap_sh_q;
        base_sh_d   = base_sh_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;

        // Writes land in the live registers only; an active run keeps its shadows.
        if (wr_commit) begin
            case (wr_addr)
                A_COUNT: count_d = merge_bytes(count_q, wr_data, wr_strb);
                A_GAP:   gap_d   = merge_bytes(gap_q,   wr_data, wr_strb);
                A_BASE:  base_d  = merge_bytes(base_q,  wr_data, wr_strb);
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_eff) begin
                    cnt_sh_d    = count_q;
                    gap_sh_d    = gap_q[GAP_WIDTH-1:0];
                    base_sh_d   = base_q;
                    sent_d      = 32'd0;
                    stop_pend_d = 1'b0;
                    state_d     = (count_q == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // STOP waits for the current beat so tvalid/tdata never drop mid-handshake.
                if (stop_p) stop_pend_d = 1'b1;
                if (beat_hs) begin
                    sent_d = sent_q + 32'd1;
                    if (is_last || stop_pend_q || stop_p) begin
                        state_d     = S_DONE;
                        stop_pend_d = 1'b0;
                    end else if (gap_sh_q != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_sh_q;
                    end
                end
            end
            S_GAP: begin
                if (stop_p) begin
                    state_d = S_DONE;
                end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    state_d = S_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, registers and shadows.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= 32'd0;
            gap_q       <= 32'd0;
            base_q      <= 32'd0;
            sent_q      <= 32'd0;
            cnt_sh_q    <= 32'd0;
            gap_sh_q    <= '0;
            base_sh_q   <= 32'd0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            base_q      <= base_d;
            sent_q      <= sent_d;
            cnt_sh_q    <= cnt_sh_d;
            gap_sh_q    <= gap_sh_d;
            base_sh_q   <= base_sh_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // AXI-lite channel latches, write response and read data.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rdy_en_q <= 1'b0;
            aw_lat_q <= 1'b0;
            awaddr_q <= 8'd0;
            w_lat_q  <= 1'b0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rdy_en_q <= 1'b1;

            if (bvalid_q && bus.s_axi_control_bready) bvalid_q <= 1'b0;

            if (wr_commit) begin
                aw_lat_q <= 1'b0;
                w_lat_q  <= 1'b0;
                bvalid_q <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_lat_q <= 1'b1;
                    awaddr_q <= bus.s_axi_control_awaddr[7:0];
                end
                if (w_hs) begin
                    w_lat_q <= 1'b1;
                    wdata_q <= bus.s_axi_control_wdata;
                    wstrb_q <= bus.s_axi_control_wstrb;
                end
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && bus.s_axi_control_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen: expected beats queued at stimulus time, compared as the stream emits them.
// Bus timing: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// All waits are cycle-bounded; an expired bound counts as a failure.
module tb_axis_traffic_gen;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;

    axis_traffic_gen_if #(.DATA_BYTES(4)) bus ();

    axis_traffic_gen #(.DATA_BYTES(4), .GAP_WIDTH(16)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tv_cycles = 0;

    typedef struct { logic [31:0] dat; logic last; int cyc; } beat_t;
    typedef struct { logic [31:0] dat; logic last; } exp_t;
    beat_t cap_q[$];
    exp_t  exp_q[$];

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Stream monitor: records every beat that will handshake at the next rising edge.
    always @(negedge ap_clk) begin
        if (ap_rst_n && bus.outstream_tvalid) begin
            tv_cycles++;
            if (bus.outstream_tready) begin
                beat_t b;
                b.dat  = bus.outstream_tdata;
                b.last = bus.outstream_tlast;
                b.cyc  = cyc;
                cap_q.push_back(b);
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l);
        exp_t e;
        e.dat  = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_ok = 0;
        bit w_ok  = 0;
        bit b_ok  = 0;
        int n = 0;
        bus.s_axi_control_awaddr  = a;
        bus.s_axi_control_wdata   = d;
        bus.s_axi_control_wstrb   = s;
        bus.s_axi_control_awvalid = 1'b1;
        bus.s_axi_control_wvalid  = 1'b1;
        while (!(aw_ok && w_ok) && n < 50) begin
            @(negedge ap_clk);
            if (bus.s_axi_control_awvalid && bus.s_axi_control_awready) aw_ok = 1;
            if (bus.s_axi_control_wvalid && bus.s_axi_control_wready) w_ok = 1;
            tick();
            if (aw_ok) bus.s_axi_control_awvalid = 1'b0;
            if (w_ok)  bus.s_axi_control_wvalid  = 1'b0;
            n++;
        end
        bus.s_axi_control_awvalid = 1'b0;
        bus.s_axi_control_wvalid  = 1'b0;
        bus.s_axi_control_bready  = 1'b1;
        n = 0;
        while (!b_ok && n < 50) begin
            @(negedge ap_clk);
            if (bus.s_axi_control_bvalid) b_ok = 1;
            tick();
            n++;
        end
        bus.s_axi_control_bready = 1'b0;
        n_checks++;
        if (!(aw_ok && w_ok && b_ok)) begin
            n_fail++;
            $display("FAIL write_timeout addr=%h aw=%0d w=%0d b=%0d required all 1", a, aw_ok, w_ok, b_ok);
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        bit ar_ok = 0;
        bit r_ok  = 0;
        int n = 0;
        d = 32'hDEAD_BEEF;
        r = 2'b11;
        bus.s_axi_control_araddr  = a;
        bus.s_axi_control_arvalid = 1'b1;
        while (!ar_ok && n < 50) begin
            @(negedge ap_clk);
            if (bus.s_axi_control_arready) ar_ok = 1;
            tick();
            n++;
        end
        bus.s_axi_control_arvalid = 1'b0;
        bus.s_axi_control_rready  = 1'b1;
        n = 0;
        while (!r_ok && n < 50) begin
            @(negedge ap_clk);
            if (bus.s_axi_control_rvalid) begin
                r_ok = 1;
                d = bus.s_axi_control_rdata;
                r = bus.s_axi_control_rresp;
            end
            tick();
            n++;
        end
        bus.s_axi_control_rready = 1'b0;
        n_checks++;
        if (!(ar_ok && r_ok)) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h ar=%0d r=%0d required both 1", a, ar_ok, r_ok);
        end
    endtask

    task automatic wait_beats(input int nb, input int budget);
        int n = 0;
        while (cap_q.size() < nb && n < budget) begin
            @(negedge ap_clk);
            n++;
        end
        repeat (6) tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        ap_rst_n = 1'b0;
        repeat (3) tick();
        @(negedge ap_clk);
        n_checks++; if (bus.outstream_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got=%b exp=0", bus.outstream_tvalid); end
        n_checks++; if (bus.outstream_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got=%b exp=0", bus.outstream_tlast); end
        n_checks++; if (bus.outstream_tdata !== 32'd0) begin n_fail++; $display("FAIL rst_tdata got=%h exp=0", bus.outstream_tdata); end
        n_checks++; if ({bus.s_axi_control_awready, bus.s_axi_control_wready, bus.s_axi_control_arready} !== 3'b000) begin
            n_fail++; $display("FAIL rst_readys got=%b exp=000", {bus.s_axi_control_awready, bus.s_axi_control_wready, bus.s_axi_control_arready}); end
        n_checks++; if ({bus.s_axi_control_bvalid, bus.s_axi_control_rvalid} !== 2'b00 || bus.s_axi_control_rdata !== 32'd0) begin
            n_fail++; $display("FAIL rst_resp got bv=%b rv=%b rdata=%h exp 0", bus.s_axi_control_bvalid, bus.s_axi_control_rvalid, bus.s_axi_control_rdata); end
        tick();
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_checks++; if (bus.s_axi_control_awready !== 1'b0) begin n_fail++; $display("FAIL rel_awready_early got=%b exp=0", bus.s_axi_control_awready); end
        tick();
        @(negedge ap_clk);
        n_checks++; if ({bus.s_axi_control_awready, bus.s_axi_control_wready, bus.s_axi_control_arready} !== 3'b111) begin
            n_fail++; $display("FAIL rel_readys got=%b exp=111", {bus.s_axi_control_awready, bus.s_axi_control_wready, bus.s_axi_control_arready}); end
        tick();
        axi_read(32'h00, d, r);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_control got=%h exp=0", d); end
        axi_read(32'h20, d, r);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_sent got=%h exp=0", d); end
    endtask

    task automatic test_count_zero();
        logic [31:0] d;
        logic [1:0]  r;
        cap_q.delete();
        bus.outstream_tready = 1'b1;
        axi_write(32'h10, 32'd0, 4'hF);
        tv_cycles = 0;
        axi_write(32'h00, 32'h1, 4'hF);
        axi_read(32'h00, d, r);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL zero_control got=%h exp=2", d); end
        repeat (4) tick();
        n_checks++; if (tv_cycles !== 0) begin n_fail++; $display("FAIL zero_tvalid_cycles got=%0d exp=0", tv_cycles); end
        axi_read(32'h20, d, r);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL zero_sent got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        int prev;
        bit have_prev = 0;
        cap_q.delete();
        bus.outstream_tready = 1'b1;
        axi_write(32'h10, 32'd4, 4'hF);
        axi_write(32'h14, 32'd0, 4'hF);
        axi_write(32'h18, 32'd10, 4'hF);
        for (int i = 0; i < 4; i++) push_exp(32'(10 + i), i == 3);
        axi_write(32'h00, 32'h1, 4'hF);
        wait_beats(4, 60);
        n_checks++; if (cap_q.size() !== 4) begin n_fail++; $display("FAIL b2b_beat_count got=%0d exp=4", cap_q.size()); end
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (cap_q.size() == 0) begin n_fail++; $display("FAIL b2b_missing exp_dat=%h got none", e.dat); end
            else begin
                beat_t b;
                b = cap_q.pop_front();
                if (b.dat !== e.dat || b.last !== e.last) begin
                    n_fail++; $display("FAIL b2b_beat got=%h/%b exp=%h/%b", b.dat, b.last, e.dat, e.last); end
                if (have_prev) begin
                    n_checks++; if (b.cyc - prev !== 1) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=1", b.cyc - prev); end
                end
                prev = b.cyc; have_prev = 1;
            end
        end
        axi_read(32'h20, d, r);
        n_checks++; if (d !== 32'd4) begin n_fail++; $display("FAIL b2b_sent got=%h exp=4", d); end
        axi_read(32'h00, d, r);
        n_checks++; if (d !== 32'h2 || r !== 2'b00) begin n_fail++; $display("FAIL b2b_control got=%h rresp=%b exp=2/00", d, r); end
        axi_read(32'h24, d, r);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0", d); end
        axi_write(32'h20, 32'h1234, 4'hF);
        axi_read(32'h20, d, r);
        n_checks++; if (d !== 32'd4) begin n_fail++; $display("FAIL sent_readonly got=%h exp=4", d); end
    endtask

    task automatic test_gap();
        logic [31:0] d;
        logic [1:0]  r;
        int prev;
        bit have_prev = 0;
        cap_q.delete();
        bus.outstream_tready = 1'b1;
        axi_write(32'h10, 32'd3, 4'hF);
        axi_write(32'h14, 32'd2, 4'hF);
        axi_write(32'h18, 32'd0, 4'hF);
        for (int i = 0; i < 3; i++) push_exp(32'(i), i == 2);
        tv_cycles = 0;
        axi_write(32'h00, 32'h1, 4'hF);
        // Restart attempt and BASE change mid-run must not disturb the run.
        axi_write(32'h00, 32'h1, 4'hF);
        axi_write(32'h18, 32'h55, 4'hF);
        wait_beats(3, 60);
        n_checks++; if (cap_q.size() !== 3) begin n_fail++; $display("FAIL gap_beat_count got=%0d exp=3", cap_q.size()); end
        n_checks++; if (tv_cycles !== 3) begin n_fail++; $display("FAIL gap_tvalid_cycles got=%0d exp=3", tv_cycles); end
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (cap_q.size() == 0) begin n_fail++; $display("FAIL gap_missing exp_dat=%h got none", e.dat); end
            else begin
                beat_t b;
                b = cap_q.pop_front();
                if (b.dat !== e.dat || b.last !== e.last) begin
                    n_fail++; $display("FAIL gap_beat got=%h/%b exp=%h/%b", b.dat, b.last, e.dat, e.last); end
                if (have_prev) begin
                    n_checks++; if (b.cyc - prev !== 3) begin n_fail++; $display("FAIL gap_spacing got=%0d exp=3", b.cyc - prev); end
                end
                prev = b.cyc; have_prev = 1;
            end
        end
        axi_read(32'h18, d, r);
        n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL gap_base_live got=%h exp=55", d); end
        axi_read(32'h20, d, r);
        n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL gap_sent got=%h exp=3", d); end
    endtask

    task automatic test_stop_stall();
        logic [31:0] d;
        logic [1:0]  r;
        cap_q.delete();
        bus.outstream_tready = 1'b0;
        axi_write(32'h10, 32'd5, 4'hF);
        axi_write(32'h14, 32'd0, 4'hF);
        axi_write(32'h18, 32'd0, 4'hF);
        push_exp(32'd0, 1'b0);
        push_exp(32'd1, 1'b0);
        axi_write(32'h00, 32'h1, 4'hF);
        bus.outstream_tready = 1'b1;
        tick();
        bus.outstream_tready = 1'b0;
        @(negedge ap_clk);
        n_checks++; if (bus.outstream_tvalid !== 1'b1 || bus.outstream_tdata !== 32'd1) begin
            n_fail++; $display("FAIL stall_beat1 got v=%b d=%h exp v=1 d=1", bus.outstream_tvalid, bus.outstream_tdata); end
        tick();
        axi_write(32'h00, 32'h2, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            n_checks++; if (bus.outstream_tvalid !== 1'b1 || bus.outstream_tdata !== 32'd1) begin
                n_fail++; $display("FAIL stall_stable cyc%0d got v=%b d=%h exp v=1 d=1", i, bus.outstream_tvalid, bus.outstream_tdata); end
            tick();
        end
        bus.outstream_tready = 1'b1;
        wait_beats(2, 20);
        n_checks++; if (cap_q.size() !== 2) begin n_fail++; $display("FAIL stop_beat_count got=%0d exp=2", cap_q.size()); end
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (cap_q.size() == 0) begin n_fail++; $display("FAIL stop_missing exp_dat=%h got none", e.dat); end
            else begin
                beat_t b;
                b = cap_q.pop_front();
                if (b.dat !== e.dat || b.last !== e.last) begin
                    n_fail++; $display("FAIL stop_beat got=%h/%b exp=%h/%b", b.dat, b.last, e.dat, e.last); end
            end
        end
        axi_read(32'h20, d, r);
        n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL stop_sent got=%h exp=2", d); end
        axi_read(32'h00, d, r);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL stop_control got=%h exp=2", d); end
    endtask

    task automatic test_start_stop();
        logic [31:0] d;
        logic [1:0]  r;
        cap_q.delete();
        tv_cycles = 0;
        axi_write(32'h00, 32'h3, 4'hF);
        repeat (6) tick();
        n_checks++; if (tv_cycles !== 0) begin n_fail++; $display("FAIL startstop_tvalid got=%0d exp=0", tv_cycles); end
        axi_read(32'h20, d, r);
        n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL startstop_sent got=%h exp=2", d); end
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        int bcount = 0;
        axi_write(32'h10, 32'h0000FF00, 4'hF);
        bus.s_axi_control_awaddr  = 32'h10;
        bus.s_axi_control_awvalid = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge ap_clk);
            if (bus.s_axi_control_awready) break;
            tick();
            n++;
        end
        tick();
        bus.s_axi_control_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge ap_clk);
            if (bus.s_axi_control_bvalid) bcount++;
            tick();
        end
        n_checks++; if (bcount !== 0) begin n_fail++; $display("FAIL wstrb_early_bvalid got=%0d exp=0", bcount); end
        bus.s_axi_control_wdata  = 32'h7;
        bus.s_axi_control_wstrb  = 4'b0001;
        bus.s_axi_control_wvalid = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge ap_clk);
            if (bus.s_axi_control_wready) break;
            tick();
            n++;
        end
        tick();
        bus.s_axi_control_wvalid = 1'b0;
        bus.s_axi_control_bready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge ap_clk);
            if (bus.s_axi_control_bvalid) begin
                bcount++;
                n_checks++; if (bus.s_axi_control_bresp !== 2'b00) begin n_fail++; $display("FAIL wstrb_bresp got=%b exp=00", bus.s_axi_control_bresp); end
            end
            tick();
        end
        bus.s_axi_control_bready = 1'b0;
        n_checks++; if (bcount !== 1) begin n_fail++; $display("FAIL wstrb_bvalid_count got=%0d exp=1", bcount); end
        axi_read(32'h10, d, r);
        n_checks++; if (d !== 32'h0000FF07) begin n_fail++; $display("FAIL wstrb_count got=%h exp=0000ff07", d); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int n = 0;
        cap_q.delete();
        bus.outstream_tready = 1'b1;
        axi_write(32'h10, 32'd8, 4'hF);
        axi_write(32'h14, 32'd0, 4'hF);
        axi_write(32'h18, 32'h100, 4'hF);
        axi_write(32'h00, 32'h1, 4'hF);
        while (n < 20) begin
            @(negedge ap_clk);
            if (bus.outstream_tvalid && bus.outstream_tdata == 32'h102) break;
            n++;
        end
        n_checks++; if (n >= 20) begin n_fail++; $display("FAIL midrst_beat2_timeout waited=%0d exp<20", n); end
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        n_checks++; if (bus.outstream_tvalid !== 1'b0 || bus.outstream_tdata !== 32'd0) begin
            n_fail++; $display("FAIL midrst_tvalid got v=%b d=%h exp 0/0", bus.outstream_tvalid, bus.outstream_tdata); end
        tick();
        ap_rst_n = 1'b1;
        tick();
        cap_q.delete();
        axi_read(32'h00, d, r);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midrst_control got=%h exp=0", d); end
        axi_read(32'h10, d, r);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midrst_count got=%h exp=0", d); end
        axi_read(32'h18, d, r);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midrst_base got=%h exp=0", d); end
        axi_read(32'h20, d, r);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midrst_sent got=%h exp=0", d); end
        axi_write(32'h10, 32'd3, 4'hF);
        axi_write(32'h18, 32'd5, 4'hF);
        for (int i = 0; i < 3; i++) push_exp(32'(5 + i), i == 2);
        axi_write(32'h00, 32'h1, 4'hF);
        wait_beats(3, 40);
        n_checks++; if (cap_q.size() !== 3) begin n_fail++; $display("FAIL fresh_beat_count got=%0d exp=3", cap_q.size()); end
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (cap_q.size() == 0) begin n_fail++; $display("FAIL fresh_missing exp_dat=%h got none", e.dat); end
            else begin
                beat_t b;
                b = cap_q.pop_front();
                if (b.dat !== e.dat || b.last !== e.last) begin
                    n_fail++; $display("FAIL fresh_beat got=%h/%b exp=%h/%b", b.dat, b.last, e.dat, e.last); end
            end
        end
    endtask

    initial begin
        bus.s_axi_control_awaddr  = 32'd0;
        bus.s_axi_control_awvalid = 1'b0;
        bus.s_axi_control_wdata   = 32'd0;
        bus.s_axi_control_wstrb   = 4'd0;
        bus.s_axi_control_wvalid  = 1'b0;
        bus.s_axi_control_bready  = 1'b0;
        bus.s_axi_control_araddr  = 32'd0;
        bus.s_axi_control_arvalid = 1'b0;
        bus.s_axi_control_rready  = 1'b0;
        bus.outstream_tready      = 1'b0;
        tick();
        test_reset();
        test_count_zero();
        test_back_to_back();
        test_gap();
        test_stop_stall();
        test_start_stop();
        test_wstrb();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_traffic_gen.md
AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, giving the outstream beat width in bytes.
REQ-002 SHALL have parameter GAP_WIDTH, default 16, giving the inter-beat gap counter width.
REQ-003 SHALL have port ap_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have AXI-lite write ports s_axi_control_awaddr in 32, awvalid in 1, awready out 1, wdata in 32, wstrb in 4, wvalid in 1, wready out 1, bresp out 2, bvalid out 1, bready in 1.
REQ-006 SHALL have AXI-lite read ports s_axi_control_araddr in 32, arvalid in 1, arready out 1, rdata out 32, rresp out 2, rvalid out 1, rready in 1.
REQ-007 SHALL have port outstream_tdata  output  DATA_BYTES*8  generated beat data.
REQ-008 SHALL have port outstream_tvalid  output  1  beat valid.
REQ-009 SHALL have port outstream_tready  input  1  downstream (measurer instream) ready.
REQ-010 SHALL have port outstream_tlast  output  1  high on final beat of a run.

Function
REQ-011 SHALL decode addr[7:0]: 0x00 CONTROL (W: bit0 START, bit1 STOP; R: bit0 busy, bit1 done), 0x10 COUNT, 0x14 GAP, 0x18 BASE, 0x20 SENT (read-only).
REQ-012 SHALL honour wstrb per byte on COUNT/GAP/BASE; CONTROL bits are 1-cycle pulses, never stored.
REQ-013 SHALL accept AW and W independently (awready/wready high while its own channel is not latched and bvalid low), commit the write in the cycle both are latched, assert bvalid next cycle, hold until bready.
REQ-014 SHALL assert arready while rvalid low; rdata/rvalid valid the cycle after AR handshake, held until rready.
REQ-015 SHALL return bresp=rresp=2'b00 always; unmapped reads return 0; unmapped writes ignored.
REQ-016 SHALL implement FSM IDLE, RUN, GAP, DONE.
REQ-017 IDLE/DONE + START: latch COUNT, GAP, BASE into shadows, clear SENT, go RUN; if COUNT==0, go DONE directly, no beat emitted.
REQ-018 RUN: tvalid=1, tdata=(BASE+SENT) truncated/zero-extended to DATA_BYTES*8, tlast=1 iff SENT==COUNT-1.
REQ-019 On RUN handshake: SENT+=1; if final beat or STOP pending -> DONE; else if GAP shadow>0 -> GAP with counter=GAP; else stay RUN (back-to-back beats).
REQ-020 GAP: tvalid=0, decrement counter; go RUN in the cycle after counter reaches 1 (exactly GAP idle cycles); STOP in GAP -> DONE immediately.
REQ-021 STOP in RUN SHALL be recorded pending; tvalid/tdata SHALL NOT change until the current beat handshakes (AXIS stability rule).
REQ-022 START while RUN/GAP SHALL be ignored; register writes during run update registers only, not shadows.
REQ-023 busy=1 in RUN/GAP; done=1 in DONE, cleared by START.
REQ-024 SENT SHALL be 32 bits, wraps modulo 2^32; BASE+SENT addition modulo 2^32.
REQ-025 Simultaneous START and STOP in same write: STOP wins, no run starts.

Reset
REQ-026 ap_rst_n low at a clock edge SHALL force IDLE, tvalid=0, tlast=0, tdata=0, awready=wready=arready=0, bvalid=rvalid=0, rdata=0, COUNT=GAP=BASE=SENT=0, pending STOP cleared, mid-beat or mid-transaction included; ready outputs rise the first cycle after release.

Verification
REQ-027 COUNT=4, GAP=0, BASE=10, tready=1, START -> beats 10,11,12,13 on 4 consecutive cycles, tlast on 13, SENT=4, CONTROL reads 0x2.
REQ-028 COUNT=3, GAP=2, BASE=0 -> beats 0,1,2 each separated by exactly 2 tvalid-low cycles.
REQ-029 COUNT=5, tready held low 3 cycles on beat 1 with STOP written then -> tdata=1 stable while stalled, run ends after beat 1 handshakes, SENT=2, done=1.
REQ-030 COUNT=0, START -> no tvalid, done=1 next cycle, SENT=0.
REQ-031 AW then W two cycles later, write COUNT=7 with wstrb=4'b0001 over prior 0x0000FF00 -> COUNT reads 0x0000FF07, single bvalid.
REQ-032 ap_rst_n low during beat 2 of 8 -> tvalid=0 next cycle, all registers 0, IDLE; fresh START runs normally.
